// File: rtl/mac_result_writer.sv
// Drains a stream of MAC results into memory: each accepted word is buffered in a small
// FIFO and written to base + k*stride through a req/gnt write port.
module mac_result_writer #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [31:0]             base_addr_i,
   input  logic [15:0]             len_i,
   input  logic [15:0]             stride_i,
   input  logic [DATA_WIDTH-1:0]   d_data_i,
   input  logic [DATA_WIDTH/8-1:0] d_strb_i,
   input  logic                    d_valid_i,
   output logic                    d_ready_o,
   output logic                    tcdm_req_o,
   input  logic                    tcdm_gnt_i,
   output logic [31:0]             tcdm_add_o,
   output logic                    tcdm_wen_o,
   output logic [DATA_WIDTH-1:0]   tcdm_data_o,
   output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [15:0]             wr_cnt_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e          state_q, state_d;
   logic [15:0]     len_q, len_d;
   logic [15:0]     stride_q, stride_d;
   logic [31:0]     addr_q, addr_d;
   logic [15:0]     acc_q, acc_d;
   logic [15:0]     wr_q, wr_d;

   logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
   logic [SW-1:0]         strb_mem_q [FIFO_DEPTH];
   logic [AW:0]           wptr_q, rptr_q;
   logic                  empty, full, push, pop;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign d_ready_o  = (state_q == RUN) && !full && (acc_q < len_q);
   assign push       = d_valid_i && d_ready_o;
   assign tcdm_req_o = !empty && ((state_q == RUN) || (state_q == DRAIN));
   assign pop        = tcdm_req_o && tcdm_gnt_i;

   // The head address is the running write address, so it only moves on a granted write.
   assign tcdm_add_o  = addr_q;
   assign tcdm_data_o = data_mem_q[rptr_q[AW-1:0]];
   assign tcdm_be_o   = strb_mem_q[rptr_q[AW-1:0]];
   assign tcdm_wen_o  = 1'b0;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign wr_cnt_o    = wr_q;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      stride_d = stride_q;
      addr_d   = addr_q;
      acc_d    = acc_q;
      wr_d     = wr_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               len_d    = len_i;
               stride_d = stride_i;
               addr_d   = base_addr_i;
               acc_d    = 16'd0;
               wr_d     = 16'd0;
               state_d  = (len_i == 16'd0) ? DONE : RUN;
            end
         end
         RUN:     if (push && (acc_q + 16'd1 == len_q)) state_d = DRAIN;
         DRAIN:   if (pop && (wr_q + 16'd1 == len_q))   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (push) acc_d = acc_q + 16'd1;
      if (pop) begin
         wr_d   = wr_q + 16'd1;
         addr_d = addr_q + {16'd0, stride_q};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         len_q    <= '0;
         stride_q <= '0;
         addr_q   <= '0;
         acc_q    <= '0;
         wr_q     <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         stride_q <= stride_d;
         addr_q   <= addr_d;
         acc_q    <= acc_d;
         wr_q     <= wr_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         data_mem_q[wptr_q[AW-1:0]] <= d_data_i;
         strb_mem_q[wptr_q[AW-1:0]] <= d_strb_i;
      end
   end

endmodule

// File: tb/tb_mac_result_writer.sv
// Randomized scoreboard bench for mac_result_writer: expected writes are queued at job
// start from base + k*stride and the word list; a monitor checks every granted write.
module tb_mac_result_writer;

   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   base_addr = '0;
   logic [15:0]   len = '0;
   logic [15:0]   stride = '0;
   logic [DW-1:0] d_data = '0;
   logic [SW-1:0] d_strb = '0;
   logic          d_valid = 1'b0;
   logic          d_ready;
   logic          tcdm_req;
   logic          tcdm_gnt = 1'b1;
   logic [31:0]   tcdm_add;
   logic          tcdm_wen;
   logic [DW-1:0] tcdm_data;
   logic [SW-1:0] tcdm_be;
   logic          busy, done;
   logic [15:0]   wr_cnt;

   mac_result_writer #(.FIFO_DEPTH(4), .DATA_WIDTH(DW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
      .len_i(len), .stride_i(stride), .d_data_i(d_data), .d_strb_i(d_strb),
      .d_valid_i(d_valid), .d_ready_o(d_ready), .tcdm_req_o(tcdm_req),
      .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add), .tcdm_wen_o(tcdm_wen),
      .tcdm_data_o(tcdm_data), .tcdm_be_o(tcdm_be), .busy_o(busy),
      .done_o(done), .wr_cnt_o(wr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   addr;
      logic [DW-1:0] data;
      logic [SW-1:0] be;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   int  done_cnt = 0;
   bit  gnt_force0 = 1'b0;
   bit  gnt_rand = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Grant driver, offset from the input drive so mode changes never race it.
   initial forever begin
      @(posedge clk);
      #2;
      tcdm_gnt = gnt_force0 ? 1'b0 : (gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
   end

   // Monitor: pops the scoreboard on every granted write and checks stall stability.
   initial begin
      wr_t           e;
      logic          p_req = 1'b0, p_gnt = 1'b0, p_rst = 1'b1;
      logic [31:0]   p_add = '0;
      logic [DW-1:0] p_data = '0;
      logic [SW-1:0] p_be = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (d_ready && !busy) chk("ready_outside_job", 1, 0);
            if (tcdm_req) chk("wen_low", tcdm_wen, 0);
            if (p_req && !p_gnt && !p_rst) begin
               chk("stall_req_hold", tcdm_req, 1);
               chk("stall_add_hold", tcdm_add, p_add);
               chk("stall_data_hold", tcdm_data, p_data);
               chk("stall_be_hold", tcdm_be, p_be);
            end
            if (tcdm_req && tcdm_gnt) begin
               if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", tcdm_add, e.addr);
                  chk("wr_data", tcdm_data, e.data);
                  chk("wr_be", tcdm_be, e.be);
               end
            end
            if (done) done_cnt++;
         end
         p_req = tcdm_req; p_gnt = tcdm_gnt; p_rst = rst;
         p_add = tcdm_add; p_data = tcdm_data; p_be = tcdm_be;
      end
   end

   task automatic run_job(input logic [31:0] b, input logic [15:0] n, input logic [15:0] s,
                          input int vprob, input bit grand, input bit hold_test,
                          input bit restart_test, input bit full_speed);
      logic [DW-1:0] dat[$];
      logic [SW-1:0] sb[$];
      wr_t           w;
      int            k = 0, cyc = 0, d0;
      for (int i = 0; i < int'(n); i++) begin
         dat.push_back($urandom);
         sb.push_back(SW'($urandom));
         w.addr = b + 32'(i) * 32'(s);
         w.data = dat[i];
         w.be   = sb[i];
         exp_q.push_back(w);
      end
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; len = n; stride = s;
      gnt_rand = grand; gnt_force0 = hold_test;
      @(posedge clk); #1;
      while (done_cnt == d0 && cyc < 2000) begin
         start = restart_test && (cyc == 2);
         base_addr = $urandom; len = n + 16'd5; stride = $urandom;
         d_valid = (k < int'(n)) && ($urandom_range(0, 99) < vprob);
         d_data  = (k < int'(n)) ? dat[k] : DW'($urandom);
         d_strb  = (k < int'(n)) ? sb[k] : SW'($urandom);
         @(negedge clk);
         if (d_valid && d_ready) k++;
         if (hold_test && cyc == 10) begin
            chk("hold_accepts", k, 4);
            chk("hold_ready_low", d_ready, 0);
            gnt_force0 = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0; d_valid = 1'b0;
      chk("done_timeout", (done_cnt != d0), 1);
      if (n == 0) chk("zero_len_latency", (cyc <= 2), 1);
      if (full_speed) chk("throughput_cycles", cyc, int'(n) + 2);
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt - d0, 1);
      chk("wr_cnt_final", wr_cnt, n);
      chk("idle_after_done", busy, 0);
      chk("all_words_accepted", k, int'(n));
      chk("scoreboard_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic reset_mid_job();
      int k = 0, cyc = 0, d0;
      wr_t w;
      for (int i = 0; i < 8; i++) begin
         w.addr = 32'h2000 + 32'(i) * 4; w.data = '0; w.be = '0;
         exp_q.push_back(w);
      end
      @(posedge clk); #1;
      start = 1'b1; base_addr = 32'h2000; len = 16'd8; stride = 16'd4; gnt_force0 = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; d_valid = 1'b1; d_data = $urandom; d_strb = '1;
      while (k < 3 && cyc < 50) begin
         @(negedge clk);
         if (d_valid && d_ready) k++;
         cyc++;
      end
      chk("reset_setup_accepts", k, 3);
      @(posedge clk); #1;
      d_valid = 1'b0;
      chk("reset_setup_req", tcdm_req, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      d0 = done_cnt;
      @(negedge clk);
      chk("abort_req", tcdm_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", d_ready, 0);
      chk("abort_wr_cnt", wr_cnt, 0);
      gnt_force0 = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_no_req", tcdm_req, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_req", tcdm_req, 0);
      chk("rst_ready", d_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_cnt", wr_cnt, 0);

      run_job(32'h1000, 16'd4, 16'd4, 100, 1'b0, 1'b0, 1'b0, 1'b1);
      run_job(32'h3000, 16'd8, 16'd4, 100, 1'b0, 1'b1, 1'b0, 1'b0);
      run_job(32'h4000, 16'd0, 16'd4, 100, 1'b0, 1'b0, 1'b0, 1'b0);
      run_job(32'hFFFF_FFF8, 16'd2, 16'd8, 100, 1'b0, 1'b0, 1'b0, 1'b0);
      run_job(32'h5000, 16'd6, 16'd12, 100, 1'b0, 1'b0, 1'b1, 1'b0);
      reset_mid_job();
      run_job(32'h6000, 16'd5, 16'd4, 100, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int j = 0; j < 8; j++)
         run_job($urandom, 16'($urandom_range(1, 20)), 16'($urandom), 70, 1'b1,
                 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
